dcache_ctrl: RTL and testbench

Controller for the 2-way set-associative data cache SRAM; the initiator side of the SRAM tag/data/hit interface. It accepts CPU load/store requests and drives SRAM lookups, word-merge writes and line refills. It also runs the write-back/allocate protocol to off-chip data memory. It sits between the MEM pipeline stage and the cache SRAM plus data memory, and stalls the pipeline on a miss.

---
 rtl/dcache_pkg.sv | 15 +
 rtl/dcache_word_sel.sv | 17 +
 rtl/dcache_ctrl.sv | 153 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared field widths, tag bit positions and controller state encoding for the
// 2-way set-associative data cache controller.
package dcache_pkg;
    localparam int TAG_W      = 23;
    localparam int INDEX_W    = 4;
    localparam int LINE_W     = 256;
    localparam int WORD_W     = 32;
    localparam int WSEL_W     = 3;
    localparam int LADDR_W    = 32 - 5;
    localparam int SRAM_TAG_W = TAG_W + 2;
    localparam int VALID_BIT  = 24;
    localparam int DIRTY_BIT  = 23;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;
endpackage

// File: rtl/dcache_word_sel.sv
// Extracts one 32-bit word from a cache line and builds the line with that
// word replaced by new store data.
module dcache_word_sel
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line,
    input  logic [WSEL_W-1:0] word_idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic [LINE_W-1:0] merged
);
    always_comb begin
        rdata  = line[word_idx*WORD_W +: WORD_W];
        merged = line;
        merged[word_idx*WORD_W +: WORD_W] = wdata;
    end
endmodule

// File: rtl/dcache_ctrl.sv
// Data cache controller: CPU load/store front end, SRAM lookup/merge/refill and
// write-back/allocate to data memory. Define DCACHE_STATS_EN for hit/miss counters.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_write_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [WORD_W-1:0]     cpu_data_i,
    output logic [WORD_W-1:0]     cpu_data_o,
    output logic                  cpu_stall_o,
    output logic [INDEX_W-1:0]    sram_addr_o,
    output logic [SRAM_TAG_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0]     sram_data_o,
    output logic                  sram_enable_o,
    output logic                  sram_write_o,
    input  logic [SRAM_TAG_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0]     sram_data_i,
    input  logic                  sram_hit_i,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [31:0]           mem_addr_o,
    output logic [LINE_W-1:0]     mem_data_o,
    input  logic [LINE_W-1:0]     mem_data_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o,
`endif
    input  logic                  mem_ack_i
);
    state_t              state;
    logic [LADDR_W-1:0]  req_line;
    logic [TAG_W-1:0]    victim_tag;
    logic [LINE_W-1:0]   victim_line;
    logic [LINE_W-1:0]   fill_line;
    logic                mem_enable_q;
    logic                mem_write_q;

    logic [TAG_W-1:0]    cur_tag;
    logic [INDEX_W-1:0]  cur_index;
    logic [WORD_W-1:0]   sel_word;
    logic [LINE_W-1:0]   merged_line;
    logic                lookup_hit;
    logic                lookup_miss;
    logic                store_hit;
    logic                unused_addr_bits;

    assign cur_tag          = cpu_addr_i[31:9];
    assign cur_index        = cpu_addr_i[8:5];
    assign lookup_hit       = cpu_req_i & sram_hit_i;
    assign lookup_miss      = cpu_req_i & ~sram_hit_i;
    assign store_hit        = lookup_hit & cpu_write_i;
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    dcache_word_sel u_word_sel (
        .line     (sram_data_i),
        .word_idx (cpu_addr_i[4:2]),
        .wdata    (cpu_data_i),
        .rdata    (sel_word),
        .merged   (merged_line)
    );

    assign cpu_data_o   = sel_word;
    assign cpu_stall_o  = (state != IDLE) | lookup_miss;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_data_o   = victim_line;
    assign mem_addr_o   = (state == WRITEBACK) ? {victim_tag, req_line[INDEX_W-1:0], 5'b0}
                                               : {req_line, 5'b0};

    // IDLE drives the lookup straight from the CPU; REFILL writes the fetched line.
    always_comb begin
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_addr_o   = req_line[INDEX_W-1:0];
        sram_tag_o    = {1'b1, 1'b0, req_line[LADDR_W-1:INDEX_W]};
        sram_data_o   = fill_line;
        case (state)
            IDLE: begin
                sram_enable_o = cpu_req_i;
                sram_write_o  = store_hit;
                sram_addr_o   = cur_index;
                sram_tag_o    = {1'b1, store_hit, cur_tag};
                sram_data_o   = merged_line;
            end
            REFILL: begin
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            req_line     <= '0;
            victim_tag   <= '0;
            victim_line  <= '0;
            fill_line    <= '0;
        end else begin
            case (state)
                IDLE: if (lookup_miss) begin
                    req_line     <= cpu_addr_i[31:5];
                    victim_tag   <= sram_tag_i[TAG_W-1:0];
                    victim_line  <= sram_data_i;
                    mem_enable_q <= 1'b1;
                    if (sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT]) begin
                        state       <= WRITEBACK;
                        mem_write_q <= 1'b1;
                    end else begin
                        state       <= ALLOCATE;
                        mem_write_q <= 1'b0;
                    end
                end
                WRITEBACK: if (mem_ack_i) begin
                    state       <= ALLOCATE;
                    mem_write_q <= 1'b0;
                end
                ALLOCATE: if (mem_ack_i) begin
                    fill_line    <= mem_data_i;
                    mem_enable_q <= 1'b0;
                    state        <= REFILL;
                end
                REFILL:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // The re-lookup right after REFILL belongs to the miss, not a new hit.
    logic relookup;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            relookup   <= 1'b0;
        end else begin
            relookup <= (state == REFILL);
            if ((state == IDLE) && lookup_hit && !relookup)
                hit_cnt_o <= hit_cnt_o + 32'd1;
            if ((state == IDLE) && lookup_miss)
                miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural 2-way SRAM and latency-programmable memory,
// with a flat-memory/LRU-list reference model predicting hits, write-backs and data.
module tb_dcache_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_enable_o, sram_write_o, sram_hit_i;
    logic         mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
`ifdef DCACHE_STATS_EN
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o),
`endif
        .mem_ack_i(mem_ack_i)
    );

    // ---------------- SRAM model: 2 ways, victim = LRU way ----------------
    logic [24:0]  s_tag  [16][2];
    logic [255:0] s_data [16][2];
    logic         s_lru  [16];
    logic         sram_clr;
    logic         h0, h1, sway;

    always_comb begin
        h0 = s_tag[sram_addr_o][0][24] && (s_tag[sram_addr_o][0][22:0] == sram_tag_o[22:0]);
        h1 = s_tag[sram_addr_o][1][24] && (s_tag[sram_addr_o][1][22:0] == sram_tag_o[22:0]);
        sway = h0 ? 1'b0 : (h1 ? 1'b1 : s_lru[sram_addr_o]);
        sram_hit_i  = sram_enable_o && (h0 || h1);
        sram_tag_i  = s_tag[sram_addr_o][sway];
        sram_data_i = s_data[sram_addr_o][sway];
    end

    always @(posedge clk_i) begin
        if (sram_clr) begin
            for (int i = 0; i < 16; i++) begin
                s_tag[i][0] <= '0; s_tag[i][1] <= '0;
                s_data[i][0] <= '0; s_data[i][1] <= '0;
                s_lru[i] <= 1'b0;
            end
        end else if (sram_enable_o && sram_write_o) begin
            s_tag[sram_addr_o][sway]  <= sram_tag_o;
            s_data[sram_addr_o][sway] <= sram_data_o;
            s_lru[sram_addr_o]        <= ~sway;
        end else if (sram_hit_i) begin
            s_lru[sram_addr_o] <= ~sway;
        end
    end

    // ---------------- memory model ----------------
    logic [31:0]  memw [logic [31:0]];
    int           lat;
    int           wb_count, rd_count;
    logic [31:0]  last_wb_addr, last_rd_addr;
    logic [255:0] last_wb_data;
    logic         resp_ack, spur_ack;

    assign mem_ack_i = resp_ack | spur_ack;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h48) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        logic [31:0]  a;
        for (int i = 0; i < 8; i++) begin
            a = la + 32'(i * 4);
            l[i*32 +: 32] = memw.exists(a) ? memw[a] : init_word(a);
        end
        return l;
    endfunction

    initial begin
        int cnt;
        cnt = 0; resp_ack = 1'b0; mem_data_i = '0; wb_count = 0; rd_count = 0;
        last_wb_addr = '0; last_rd_addr = '0; last_wb_data = '0;
        forever begin
            @(negedge clk_i);
            if (resp_ack) begin resp_ack = 1'b0; cnt = 0; end
            if (mem_enable_o && !rst_i) begin
                cnt++;
                if (cnt >= lat) begin
                    resp_ack = 1'b1;
                    if (mem_write_o) begin
                        wb_count++;
                        last_wb_addr = mem_addr_o;
                        last_wb_data = mem_data_o;
                        for (int i = 0; i < 8; i++) memw[mem_addr_o + 32'(i * 4)] = mem_data_o[i*32 +: 32];
                    end else begin
                        rd_count++;
                        last_rd_addr = mem_addr_o;
                        mem_data_i = mem_line(mem_addr_o);
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    int          mru_l [16];
    int          lru_l [16];
    bit          dirty_l [int];
    logic [31:0] refw [logic [31:0]];
    int          exp_hits, exp_miss;
    int          checks, errors;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return refw.exists(a) ? refw[a] : init_word(a);
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = ref_word(la + 32'(i * 4));
        return l;
    endfunction

    task automatic ref_access(input bit w, input logic [31:0] addr, input logic [31:0] data,
                              output bit hit, output bit wb, output logic [31:0] victim,
                              output logic [255:0] wb_line, output logic [31:0] rd);
        int line, s, vic;
        line = int'(addr & 32'hFFFF_FFE0);
        s    = int'(addr[8:5]);
        hit  = (mru_l[s] == line) || (lru_l[s] == line);
        wb = 1'b0; victim = '0; wb_line = '0;
        rd = ref_word(addr);
        if (hit) begin
            if (lru_l[s] == line) begin lru_l[s] = mru_l[s]; mru_l[s] = line; end
            if (w) dirty_l[line] = 1'b1;
            exp_hits++;
        end else begin
            vic = lru_l[s];
            if (vic != -1 && dirty_l.exists(vic) && dirty_l[vic]) begin
                wb = 1'b1; victim = 32'(vic); wb_line = ref_line(32'(vic));
            end
            if (vic != -1) dirty_l[vic] = 1'b0;
            lru_l[s] = mru_l[s];
            mru_l[s] = line;
            dirty_l[line] = w;
            exp_miss++;
        end
        if (w) refw[addr] = data;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU access, held until the stall drops, then completed on the next edge.
    task automatic access(input bit w, input logic [31:0] addr, input logic [31:0] data);
        bit eh, ewb;
        logic [31:0]  victim, exp_rd;
        logic [255:0] exp_wb_line;
        int cyc, en, wb0, rd0, exp_stall;
        ref_access(w, addr, data, eh, ewb, victim, exp_wb_line, exp_rd);
        wb0 = wb_count; rd0 = rd_count; cyc = 0; en = 0;
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_write_i = w; cpu_addr_i = addr; cpu_data_i = data;
        #1;
        while (cpu_stall_o && cyc < 400) begin
            if (mem_enable_o) en++;
            @(negedge clk_i); #1;
            cyc++;
        end
        exp_stall = eh ? 0 : (2 + lat + (ewb ? lat : 0));
        chk("stall_cycles", 256'(cyc), 256'(exp_stall));
        chk("wb_count", 256'(wb_count - wb0), 256'(ewb ? 1 : 0));
        chk("rd_count", 256'(rd_count - rd0), 256'(eh ? 0 : 1));
        if (!eh) begin
            chk("mem_en_cycles", 256'(en), 256'(ewb ? 2 * lat : lat));
            chk("alloc_addr", 256'(last_rd_addr), 256'(addr & 32'hFFFF_FFE0));
        end
        if (ewb) begin
            chk("wb_addr", 256'(last_wb_addr), 256'(victim));
            chk("wb_data", last_wb_data, exp_wb_line);
        end
        if (w) begin
            chk("store_sram_write", 256'(sram_write_o), 256'(1));
            chk("store_tag", 256'(sram_tag_o), 256'({2'b11, addr[31:9]}));
            chk("store_word", 256'(sram_data_o[addr[4:2]*32 +: 32]), 256'(data));
        end else begin
            chk("load_sram_write", 256'(sram_write_o), 256'(0));
            chk("load_data", 256'(cpu_data_o), 256'(exp_rd));
        end
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
    endtask

    initial begin
        logic [22:0] t;
        logic [3:0]  s;
        logic [2:0]  wd;
        checks = 0; errors = 0; exp_hits = 0; exp_miss = 0;
        rst_i = 1'b1; sram_clr = 1'b1; spur_ack = 1'b0; lat = 1;
        cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        for (int i = 0; i < 16; i++) begin mru_l[i] = -1; lru_l[i] = -1; end
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_stall", 256'(cpu_stall_o), 256'(0));
        chk("rst_mem_en", 256'(mem_enable_o), 256'(0));
        chk("rst_mem_wr", 256'(mem_write_o), 256'(0));
        chk("rst_sram_wr", 256'(sram_write_o), 256'(0));
        rst_i = 1'b0; sram_clr = 1'b0;

        access(1'b0, 32'h40, '0);                   // cold miss, clean victim
        access(1'b1, 32'h44, 32'h12345678);         // store hit
        @(negedge clk_i); spur_ack = 1'b1;
        @(negedge clk_i); #1;
        chk("spur_ack_mem_en", 256'(mem_enable_o), 256'(0));
        chk("spur_ack_stall", 256'(cpu_stall_o), 256'(0));
        spur_ack = 1'b0;
        access(1'b0, 32'h44, '0);
        access(1'b1, 32'h240, 32'hCAFE0001);        // second way of set 2, dirty
`ifdef DCACHE_STATS_EN
        chk("hit_cnt", 256'(hit_cnt_o), 256'(2));
        chk("miss_cnt", 256'(miss_cnt_o), 256'(2));
`endif
        access(1'b0, 32'h440, '0);                  // evicts dirty 0x40
        chk("wb_line_word1", 256'(last_wb_data[63:32]), 256'(32'h12345678));
        chk("wb_line_word2", 256'(last_wb_data[95:64]), 256'(32'hDEADBEEF));
        lat = 10;
        access(1'b1, 32'h640, 32'h0BADF00D);        // slow memory, write-back + allocate

        // Reset while ALLOCATE is waiting on memory.
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h1000;
        repeat (4) @(negedge clk_i);
        #1;
        chk("pre_rst_mem_en", 256'(mem_enable_o), 256'(1));
        chk("pre_rst_mem_addr", 256'(mem_addr_o), 256'(32'h1000));
        rst_i = 1'b1; cpu_req_i = 1'b0;
        @(posedge clk_i); #1;
        chk("mid_rst_mem_en", 256'(mem_enable_o), 256'(0));
        chk("mid_rst_stall", 256'(cpu_stall_o), 256'(0));
        chk("mid_rst_mem_wr", 256'(mem_write_o), 256'(0));
        chk("mid_rst_sram_wr", 256'(sram_write_o), 256'(0));
        @(negedge clk_i); rst_i = 1'b0;
        exp_hits = 0; exp_miss = 0;
        access(1'b0, 32'h1000, '0);                 // must miss again

        for (int n = 0; n < 150; n++) begin
            lat = $urandom_range(1, 4);
            case ($urandom_range(0, 2))
                0:       s = 4'd0;
                1:       s = 4'd2;
                default: s = 4'd7;
            endcase
            t  = 23'($urandom_range(0, 3));
            wd = 3'($urandom_range(0, 7));
            access(1'($urandom_range(0, 1)), {t, s, wd, 2'b00}, $urandom);
        end
`ifdef DCACHE_STATS_EN
        chk("final_hit_cnt", 256'(hit_cnt_o), 256'(exp_hits));
        chk("final_miss_cnt", 256'(miss_cnt_o), 256'(exp_miss));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
